// File: rtl/pll_clock_manager.sv
// pll_clock_manager
//   Turns the raw PLL clock and lock into a safe system clock domain.
//   PLL lock is synchronised and filtered. SYS_RESET is held until lock has
//   been stable for LOCK_FILTER cycles, and then for RESET_HOLD more cycles.
//   In RUN, CHANNELS phase accumulators produce fractional clock-enable
//   pulses. Each increment can be reprogrammed at runtime. When lock is lost
//   in RUN, the loss is counted and the domain goes back into reset.
//
// Ports
//   CLK             in   PLL output clock (only clock)
//   RESET           in   synchronous active-high reset
//   PLL_LOCK        in   raw PLL lock, asynchronous to CLK
//   INC_WE          in   increment write strobe
//   INC_SEL         in   channel select for the increment write
//   INC_DATA        in   new increment value
//   CE              out  one-cycle clock-enable pulses, one bit per channel
//   SYS_RESET       out  synchronous active-high reset for downstream logic
//   READY           out  high while in RUN
//   LOCK_LOST_COUNT out  saturating count of lock losses seen in RUN
module pll_clock_manager #(
    parameter int                            CHANNELS    = 2,
    parameter int                            ACC_WIDTH   = 24,
    parameter int                            LOCK_FILTER = 1024,
    parameter int                            RESET_HOLD  = 16,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] INC_INIT    = '0
) (
    input  logic                                                CLK,
    input  logic                                                RESET,
    input  logic                                                PLL_LOCK,
    input  logic                                                INC_WE,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] INC_SEL,
    input  logic [ACC_WIDTH-1:0]                                INC_DATA,
    output logic [CHANNELS-1:0]                                 CE,
    output logic                                                SYS_RESET,
    output logic                                                READY,
    output logic [7:0]                                          LOCK_LOST_COUNT
);

    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_MAX = (LOCK_FILTER > RESET_HOLD) ? LOCK_FILTER : RESET_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        FILTER,
        HOLD,
        RUN
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync1_q;
    logic                   sync2_q;
    logic [7:0]             lost_q;
    logic [CHANNELS-1:0]    ce_q;
    logic [ACC_WIDTH-1:0]   acc_q [CHANNELS];
    logic [ACC_WIDTH-1:0]   inc_q [CHANNELS];
    logic [ACC_WIDTH:0]     sum_d [CHANNELS];
    logic                   lock_s;
    logic                   acc_run;

    assign lock_s = sync2_q;

    // Accumulators advance only on edges where RUN is held. The edge that
    // leaves RUN clears them.
    assign acc_run = (state_q == RUN) && lock_s;

    // The carry out of the (ACC_WIDTH+1)-bit sum is the clock-enable.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            sum_d[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lost_q  <= '0;
            ce_q    <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INC_INIT[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end else begin
            sync1_q <= PLL_LOCK;
            sync2_q <= sync1_q;

            case (state_q)
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= FILTER;
                        cnt_q   <= '0;
                    end
                end
                FILTER: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (cnt_q == CNT_W'(LOCK_FILTER - 1)) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                    end else if (cnt_q == CNT_W'(RESET_HOLD - 1)) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        if (lost_q != 8'hFF) begin
                            lost_q <= lost_q + 8'd1;
                        end
                    end
                end
                default: state_q <= WAIT_LOCK;
            endcase

            // The increment write takes effect from the next edge. The sum on
            // this edge still uses the old increment. Out-of-range selects
            // match no channel, so those writes are dropped.
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (INC_WE && (INC_SEL == SEL_W'(i))) begin
                    inc_q[i] <= INC_DATA;
                end
                if (acc_run) begin
                    acc_q[i] <= sum_d[i][ACC_WIDTH-1:0];
                    ce_q[i]  <= sum_d[i][ACC_WIDTH];
                end else begin
                    acc_q[i] <= '0;
                    ce_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign CE              = ce_q;
    assign SYS_RESET       = (state_q != RUN);
    assign READY           = (state_q == RUN);
    assign LOCK_LOST_COUNT = lost_q;

endmodule

// File: tb/tb_pll_clock_manager.sv
// tb_pll_clock_manager
//   Self-checking bench for pll_clock_manager. Three channels are used so
//   that an out-of-range INC_SEL (3) can be driven. Every cycle, the outputs
//   are compared with a behavioural model. The model tracks how many
//   consecutive edges have seen synchronised lock high, and the accumulator
//   values as plain integers taken modulo 2^ACC_WIDTH.
module tb_pll_clock_manager;

    localparam int CH = 3;
    localparam int AW = 24;
    localparam int LF = 8;
    localparam int RH = 4;
    localparam logic [CH*AW-1:0] INIT = {24'h000000, 24'h555556, 24'h400000};
    localparam longint unsigned MOD = 64'd1 << AW;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          PLL_LOCK;
    logic          INC_WE;
    logic [1:0]    INC_SEL;
    logic [AW-1:0] INC_DATA;
    logic [CH-1:0] CE;
    logic          SYS_RESET;
    logic          READY;
    logic [7:0]    LOCK_LOST_COUNT;

    pll_clock_manager #(
        .CHANNELS    (CH),
        .ACC_WIDTH   (AW),
        .LOCK_FILTER (LF),
        .RESET_HOLD  (RH),
        .INC_INIT    (INIT)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .PLL_LOCK        (PLL_LOCK),
        .INC_WE          (INC_WE),
        .INC_SEL         (INC_SEL),
        .INC_DATA        (INC_DATA),
        .CE              (CE),
        .SYS_RESET       (SYS_RESET),
        .READY           (READY),
        .LOCK_LOST_COUNT (LOCK_LOST_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit              h1, h2;
    int              streak;
    bit              m_ready;
    int              m_lost;
    longint unsigned m_acc [CH];
    longint unsigned m_inc [CH];
    logic [CH-1:0]   m_ce;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [CH*AW-1:0] init_v;
        bit ls;
        bit adv;
        longint unsigned s;
        init_v = INIT;
        if (RESET) begin
            h1 = 0; h2 = 0; streak = 0; m_ready = 0; m_lost = 0; m_ce = '0;
            for (int i = 0; i < CH; i++) begin
                m_acc[i] = 0;
                m_inc[i] = longint'(init_v[i*AW +: AW]);
            end
        end else begin
            ls  = h2;
            adv = m_ready && ls;
            for (int i = 0; i < CH; i++) begin
                if (adv) begin
                    s        = m_acc[i] + m_inc[i];
                    m_ce[i]  = (s >= MOD);
                    m_acc[i] = s % MOD;
                end else begin
                    m_acc[i] = 0;
                    m_ce[i]  = 1'b0;
                end
            end
            if (m_ready && !ls && m_lost < 255) m_lost++;
            if (ls) begin
                if (streak < 1000000) streak++;
            end else begin
                streak = 0;
            end
            m_ready = (streak >= LF + RH + 1);
            if (INC_WE && INC_SEL < CH) m_inc[INC_SEL] = longint'(INC_DATA);
            h2 = h1;
            h1 = PLL_LOCK;
        end
    endtask

    task automatic check_all();
        check("ce", 64'(CE), 64'(m_ce));
        check("sys_reset", 64'(SYS_RESET), 64'(!m_ready));
        check("ready", 64'(READY), 64'(m_ready));
        check("lost_count", 64'(LOCK_LOST_COUNT), 64'(m_lost));
    endtask

    // Inputs change only between a negedge and the next posedge.
    task automatic cyc();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_all();
        INC_WE = 1'b0;
    endtask

    task automatic wait_ready(input int maxc, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (READY !== 1'b1 && n < maxc);
        if (READY !== 1'b1) check("ready_timeout", 64'(READY), 64'd1);
    endtask

    task automatic wait_sysrst(input int maxc, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (SYS_RESET !== 1'b1 && n < maxc);
        if (SYS_RESET !== 1'b1) check("sysrst_timeout", 64'(SYS_RESET), 64'd1);
    endtask

    task automatic do_reset(input int cycles);
        RESET = 1'b1;
        for (int i = 0; i < cycles; i++) cyc();
        RESET = 1'b0;
    endtask

    initial begin
        int n;
        int c0, c1, c2;
        RESET = 1'b1; PLL_LOCK = 1'b0; INC_WE = 1'b0; INC_SEL = '0; INC_DATA = '0;

        // Clean lock-up latency, CE quiet before READY.
        do_reset(3);
        cyc(); cyc();
        PLL_LOCK = 1'b1;
        wait_ready(40, n);
        check("lock_latency", 64'(n), 64'(LF + RH + 3));

        // First ch0 pulse on the 4th edge after READY rises.
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("ch0_first", 64'(CE[0]), 64'(k == 4));
        end
        c0 = 0; c1 = 0;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            c0 += int'(CE[0]);
            c1 += int'(CE[1]);
        end
        check("ch0_rate", 64'(c0), 64'd750);
        check("ch1_rate_ok", 64'(c1 >= 999 && c1 <= 1001), 64'd1);

        // Glitch during FILTER restarts the lock sequence and is not counted.
        do_reset(2);
        PLL_LOCK = 1'b0;
        cyc(); cyc();
        PLL_LOCK = 1'b1;
        for (int k = 0; k < 7; k++) cyc();
        PLL_LOCK = 1'b0;
        for (int k = 0; k < 3; k++) cyc();
        PLL_LOCK = 1'b1;
        wait_ready(40, n);
        check("glitch_latency", 64'(n), 64'(LF + RH + 3));
        check("glitch_not_counted", 64'(LOCK_LOST_COUNT), 64'd0);

        // Lock loss in RUN.
        for (int k = 0; k < 5; k++) cyc();
        PLL_LOCK = 1'b0;
        wait_sysrst(10, n);
        check("loss_latency", 64'(n), 64'd3);
        check("loss_ce", 64'(CE), 64'd0);
        check("loss_count1", 64'(LOCK_LOST_COUNT), 64'd1);
        for (int r = 0; r < 299; r++) begin
            PLL_LOCK = 1'b1;
            wait_ready(40, n);
            PLL_LOCK = 1'b0;
            wait_sysrst(10, n);
        end
        check("loss_saturate", 64'(LOCK_LOST_COUNT), 64'd255);

        // Write during WAIT_LOCK, then a phase-continuous write in RUN.
        INC_WE = 1'b1; INC_SEL = 2'd0; INC_DATA = 24'h100000;
        cyc();
        PLL_LOCK = 1'b1;
        wait_ready(40, n);
        cyc(); cyc();
        INC_WE = 1'b1; INC_SEL = 2'd0; INC_DATA = 24'h800000;
        cyc();
        check("wr_old_inc", 64'(CE[0]), 64'd0);
        cyc();
        check("wr_new_inc0", 64'(CE[0]), 64'd0);
        cyc();
        check("wr_new_inc1", 64'(CE[0]), 64'd1);
        INC_WE = 1'b1; INC_SEL = 2'd3; INC_DATA = 24'hFFFFFF;
        cyc();
        c2 = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            c2 += int'(CE[2]);
        end
        check("sel_oob_ignored", 64'(c2), 64'd0);

        // Randomised lock behaviour and increment writes.
        for (int k = 0; k < 3000; k++) begin
            if (PLL_LOCK) begin
                if ($urandom_range(0, 59) == 0) PLL_LOCK = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) PLL_LOCK = 1'b1;
            end
            INC_WE  = ($urandom_range(0, 15) == 0);
            INC_SEL = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       INC_DATA = '0;
                1:       INC_DATA = '1;
                default: INC_DATA = AW'($urandom);
            endcase
            cyc();
        end

        // RESET in RUN together with a write: the write is discarded.
        INC_WE = 1'b0;
        PLL_LOCK = 1'b1;
        wait_ready(60, n);
        RESET = 1'b1; INC_WE = 1'b1; INC_SEL = 2'd0; INC_DATA = 24'h123456;
        cyc();
        check("rst_ready", 64'(READY), 64'd0);
        check("rst_lost", 64'(LOCK_LOST_COUNT), 64'd0);
        RESET = 1'b0;
        wait_ready(40, n);
        check("rst_latency", 64'(n), 64'(LF + RH + 3));
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("rst_inc_init", 64'(CE[0]), 64'(k == 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
